// File: rtl/bcd_time_counter.sv
// bcd_time_counter: 24-hour BCD time-of-day counter (hh:mm[:ss]).
// Counts up or down on a one-cycle tick, and accepts a validated parallel load.
// Produces a day carry/borrow pulse and a 12-hour display view with a PM flag.
// Ports:
//   clk, reset        single clock; synchronous active-high reset
//   tick, count_en    count strobe and its enable
//   count_down        direction, sampled with tick
//   mode_12h          selects the 12h hour view (display only)
//   load_new, new_*   one-cycle load request with BCD hour/minute/second
//   hr_out, min_out, sec_out, pm   time outputs (hr_out is combinational)
//   day_wrap, load_err             one-cycle status pulses
module bcd_time_counter #(
  parameter int unsigned HAS_SECONDS = 1,
  parameter logic [7:0]  RESET_HR    = 8'h00,
  parameter logic [7:0]  RESET_MIN   = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       count_en,
  input  logic       count_down,
  input  logic       mode_12h,
  input  logic       load_new,
  input  logic [7:0] new_hr,
  input  logic [7:0] new_min,
  input  logic [7:0] new_sec,
  output logic [7:0] hr_out,
  output logic [7:0] min_out,
  output logic [7:0] sec_out,
  output logic       pm,
  output logic       day_wrap,
  output logic       load_err
);

  localparam int unsigned DW = 4;
  localparam logic        SECS_ON = (HAS_SECONDS != 0);

  // Next value of one BCD digit that cycles 0..top.
  function automatic logic [DW-1:0] step_dig(input logic [DW-1:0] d,
                                             input logic [DW-1:0] top,
                                             input logic          dn);
    if (dn) return (d == DW'(0)) ? top : d - DW'(1);
    else    return (d == top) ? DW'(0) : d + DW'(1);
  endfunction

  // Digit is at the point where it carries (up) or borrows (down).
  function automatic logic at_lim(input logic [DW-1:0] d,
                                  input logic [DW-1:0] top,
                                  input logic          dn);
    return dn ? (d == DW'(0)) : (d == top);
  endfunction

  function automatic logic legal_time(input logic [7:0] h,
                                      input logic [7:0] m,
                                      input logic [7:0] s);
    logic ok;
    ok = (h[7:4] <= 4'd2) && (h[3:0] <= 4'd9) &&
         ((h[7:4] != 4'd2) || (h[3:0] <= 4'd3)) &&
         (m[7:4] <= 4'd5) && (m[3:0] <= 4'd9);
    if (SECS_ON) ok = ok && (s[7:4] <= 4'd5) && (s[3:0] <= 4'd9);
    return ok;
  endfunction

  function automatic logic is_pm(input logic [7:0] h);
    return (h[7:4] == 4'd2) || ((h[7:4] == 4'd1) && (h[3:0] >= 4'd2));
  endfunction

  logic [DW-1:0] hr_ms_q, hr_ls_q, min_ms_q, min_ls_q, sec_ms_q, sec_ls_q;
  logic [DW-1:0] hr_ms_d, hr_ls_d, min_ms_d, min_ls_d, sec_ms_d, sec_ls_d;
  logic          day_wrap_q, day_wrap_d;
  logic          load_err_q, load_err_d;
  logic          pm_q;

  logic          cin_sec_ms, cin_min_ls, cin_min_ms, cin_hr;
  logic          hr_lim;

  // Ripple carry/borrow enables: a digit moves only when every lower digit is at its limit.
  always_comb begin
    cin_sec_ms = SECS_ON && at_lim(sec_ls_q, 4'd9, count_down);
    cin_min_ls = SECS_ON ? (cin_sec_ms && at_lim(sec_ms_q, 4'd5, count_down)) : 1'b1;
    cin_min_ms = cin_min_ls && at_lim(min_ls_q, 4'd9, count_down);
    cin_hr     = cin_min_ms && at_lim(min_ms_q, 4'd5, count_down);
    hr_lim     = count_down ? ({hr_ms_q, hr_ls_q} == 8'h00)
                            : ({hr_ms_q, hr_ls_q} == 8'h23);
  end

  // Next-state: load takes precedence over a qualified tick.
  always_comb begin
    hr_ms_d    = hr_ms_q;
    hr_ls_d    = hr_ls_q;
    min_ms_d   = min_ms_q;
    min_ls_d   = min_ls_q;
    sec_ms_d   = sec_ms_q;
    sec_ls_d   = sec_ls_q;
    day_wrap_d = 1'b0;
    load_err_d = 1'b0;

    if (load_new) begin
      if (legal_time(new_hr, new_min, new_sec)) begin
        {hr_ms_d, hr_ls_d}   = new_hr;
        {min_ms_d, min_ls_d} = new_min;
        {sec_ms_d, sec_ls_d} = SECS_ON ? new_sec : 8'h00;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (tick && count_en) begin
      if (!legal_time({hr_ms_q, hr_ls_q}, {min_ms_q, min_ls_q}, {sec_ms_q, sec_ls_q})) begin
        // Defensive recovery from a corrupted register.
        {hr_ms_d, hr_ls_d}   = RESET_HR;
        {min_ms_d, min_ls_d} = RESET_MIN;
        {sec_ms_d, sec_ls_d} = 8'h00;
      end else begin
        if (SECS_ON) begin
          sec_ls_d = step_dig(sec_ls_q, 4'd9, count_down);
          if (cin_sec_ms) sec_ms_d = step_dig(sec_ms_q, 4'd5, count_down);
        end
        if (cin_min_ls) min_ls_d = step_dig(min_ls_q, 4'd9, count_down);
        if (cin_min_ms) min_ms_d = step_dig(min_ms_q, 4'd5, count_down);
        if (cin_hr) begin
          if (hr_lim) begin
            {hr_ms_d, hr_ls_d} = count_down ? 8'h23 : 8'h00;
            day_wrap_d         = 1'b1;
          end else begin
            hr_ls_d = step_dig(hr_ls_q, 4'd9, count_down);
            if (at_lim(hr_ls_q, 4'd9, count_down))
              hr_ms_d = step_dig(hr_ms_q, 4'd2, count_down);
          end
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      {hr_ms_q, hr_ls_q}   <= RESET_HR;
      {min_ms_q, min_ls_q} <= RESET_MIN;
      {sec_ms_q, sec_ls_q} <= 8'h00;
      day_wrap_q           <= 1'b0;
      load_err_q           <= 1'b0;
      pm_q                 <= is_pm(RESET_HR);
    end else begin
      hr_ms_q    <= hr_ms_d;
      hr_ls_q    <= hr_ls_d;
      min_ms_q   <= min_ms_d;
      min_ls_q   <= min_ls_d;
      sec_ms_q   <= sec_ms_d;
      sec_ls_q   <= sec_ls_d;
      day_wrap_q <= day_wrap_d;
      load_err_q <= load_err_d;
      pm_q       <= is_pm({hr_ms_d, hr_ls_d});
    end
  end

  // 12h view: 00->12, 13..19->01..07, 20/21->08/09, 22/23->10/11, else unchanged.
  always_comb begin
    hr_out = {hr_ms_q, hr_ls_q};
    if (mode_12h) begin
      if ({hr_ms_q, hr_ls_q} == 8'h00) begin
        hr_out = 8'h12;
      end else if (hr_ms_q == 4'd1 && hr_ls_q >= 4'd3) begin
        hr_out = {4'd0, hr_ls_q - 4'd2};
      end else if (hr_ms_q == 4'd2 && hr_ls_q <= 4'd1) begin
        hr_out = {4'd0, hr_ls_q + 4'd8};
      end else if (hr_ms_q == 4'd2) begin
        hr_out = {4'd1, hr_ls_q - 4'd2};
      end
    end
  end

  assign min_out  = {min_ms_q, min_ls_q};
  assign sec_out  = {sec_ms_q, sec_ls_q};
  assign pm       = pm_q;
  assign day_wrap = day_wrap_q;
  assign load_err = load_err_q;

endmodule

// File: doc/bcd_time_counter.md
Name: bcd_time_counter

Overview:
- Parametrised successor to the team's hh:mm loadable BCD time counter.
- Keeps a 24-hour BCD time of day: hours, minutes and optional seconds.
- Counts up or down on a single-cycle tick, with validated parallel load, count enable and a day carry/borrow pulse.
- Offers a 12-hour display view with a PM flag. Sits between the tick generator and the display/alarm-compare logic.

Parameters:
- HAS_SECONDS, 1, 1 = seconds digits present and tick is one_second; 0 = tick is one_minute, second outputs tie to 0.
- RESET_HR, 8'h00, BCD hour (24h) loaded on reset; must be a legal value.
- RESET_MIN, 8'h00, BCD minute loaded on reset; must be a legal value.

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- tick  in  1  one-cycle count strobe (one_second or one_minute per HAS_SECONDS)
- count_en  in  1  1 = ticks are honoured; 0 = ticks ignored
- count_down  in  1  0 = count up, 1 = count down; sampled with tick
- mode_12h  in  1  display format select; affects outputs only, never stored time
- load_new  in  1  load request, one cycle
- new_hr  in  8  BCD hour, always 24h format, {ms,ls}
- new_min  in  8  BCD minute {ms,ls}
- new_sec  in  8  BCD second {ms,ls}; ignored when HAS_SECONDS=0
- hr_out  out  8  BCD hour, 24h or 12h view
- min_out  out  8  BCD minute
- sec_out  out  8  BCD second; 8'h00 when HAS_SECONDS=0
- pm  out  1  1 when stored hour ≥ 12 (valid in both modes)
- day_wrap  out  1  one-cycle pulse on 23:59[:59]→00:00[:00] up, or 00:00[:00]→23:59[:59] down
- load_err  out  1  one-cycle pulse when a load is rejected

Behaviour:
- Priority per edge: reset > load_new > (tick & count_en). A tick on the same edge as load_new is dropped.
- Reset:
  - Stored time = RESET_HR:RESET_MIN:00.
  - day_wrap = 0, load_err = 0.
  - Reset mid-count discards all in-flight state; no wrap pulse is generated.
- Load:
  - Accepted only if all of the following hold: ms_hr ≤ 2; ls_hr ≤ 9; ls_hr ≤ 3 when ms_hr = 2; ms_min ≤ 5; ls_min ≤ 9; and, when HAS_SECONDS=1, ms_sec ≤ 5 and ls_sec ≤ 9.
  - Accepted: stored time = new value on that edge. When HAS_SECONDS=0, seconds are forced to 0.
  - Rejected: stored time unchanged; load_err = 1 for exactly the next cycle.
  - Load is honoured regardless of count_en.
- Count up, one step per qualified tick, cascading BCD:
  - Least-significant digit 9→0 carries into its pair's ms digit.
  - ms_sec/ms_min 5→0 carries into the next field.
  - Hour 09→10 and 19→20 carry ls_hr into ms_hr.
  - Hour 23 plus carry → 00, and day_wrap = 1 for one cycle.
- Count down: the exact mirror.
  - 0 borrows to 9 on ls digits; ms_sec/ms_min 0 borrows to 5.
  - Hour 10→09 and 20→19.
  - 00:00[:00] → 23:59[:59], with day_wrap = 1.
- Latency: tick sampled at edge N; new time and day_wrap are visible after edge N. Ticks on consecutive cycles each advance by one step.
- count_en = 0: time holds; load still works.
- Outputs:
  - min_out, sec_out and pm are direct register views.
  - hr_out is combinational from the stored hour.
  - mode_12h = 0: hr_out = stored hour.
  - mode_12h = 1: 00→12; 01–12 unchanged; 13–21 → 01–09; 22→10; 23→11.
  - mode_12h may change on any cycle without disturbing stored time.
- Illegal stored states are unreachable. Defensive rule: any illegal stored digit is forced to RESET_HR:RESET_MIN:00 on the next tick.
- All arithmetic is per-digit 4-bit BCD; no binary hour/minute counters.

Test Plan:
- Reset, then up count:
  - reset high 1 cycle → 00:00:00, pm = 0, day_wrap = 0, load_err = 0.
  - 61 ticks → 00:01:01.
- Up wrap: load 23:59:59, one tick → 00:00:00, day_wrap = 1 for one cycle only, pm 1→0.
- Up and down carries:
  - Up: load 09:59:59, tick → 10:00:00.
  - Down: load 20:00:00, count_down = 1, tick → 19:59:59.
  - Down: load 00:00:00, count_down = 1, tick → 23:59:59, day_wrap = 1.
- Load validation:
  - load 24:00:00 → rejected: time held, load_err = 1 for one cycle.
  - load 12:60:00 → rejected.
  - load 23:45:30 → accepted, load_err = 0.
  - load_new and tick on the same edge → loaded value is shown, not loaded value + 1.
- 12h view with mode_12h = 1:
  - 00:15 → hr_out 12, pm = 0.
  - 12:00 → hr_out 12, pm = 1.
  - 13:05 → hr_out 01, pm = 1.
  - 23:00 → hr_out 11, pm = 1.
  - Toggling mode_12h leaves stored time unchanged.
- Enable and reset interaction:
  - count_en = 0 with 10 ticks → time unchanged.
  - reset asserted in the same cycle as tick and load_new → RESET value wins.
  - HAS_SECONDS = 0 build: 60 ticks from 00:00 → 01:00, sec_out = 00.
